// File: rtl/nes_alu_pkg.sv
// Shared definitions for the 8-bit ALU and its sequencer: opcodes, flag
// bit positions, sequencer states and request legality.
package nes_alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_INC    = 5'd5;
  localparam logic [4:0] OP_DEC    = 5'd6;
  localparam logic [4:0] OP_SHR    = 5'd7;
  localparam logic [4:0] OP_SHL    = 5'd8;
  localparam logic [4:0] OP_RTR    = 5'd9;
  localparam logic [4:0] OP_RTL    = 5'd10;
  localparam logic [4:0] OP_RSVD11 = 5'd11;
  localparam logic [4:0] OP_LD     = 5'd12;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC_LO,
    S_WAIT_LO,
    S_EXEC_HI,
    S_WAIT_HI,
    S_RESP
  } seq_state_t;

  // Only ADD/SUB have a chained 16-bit form; 11 and everything above LD are unassigned.
  function automatic logic op_legal(input logic [4:0] op, input logic wide);
    logic ok;
    ok = (op <= OP_LD) && (op != OP_RSVD11);
    if (wide && (op != OP_ADD) && (op != OP_SUB)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/alu_flag_unit.sv
// Combinational N/V/Z/C derivation for one ALU pass, plus the per-op mask
// that limits which of the requested flags an op may actually change.
module alu_flag_unit
  import nes_alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [7:0] r,
  input  logic       low_zero,
  input  logic [4:0] op,
  input  logic [3:0] mask,
  output logic [3:0] flags,
  output logic [3:0] eff_mask
);

  logic [8:0] sum9;
  logic [8:0] sub_rhs;

  assign sum9    = {1'b0, a} + {1'b0, b} + {8'h00, cin};
  assign sub_rhs = {1'b0, b} + {8'h00, ~cin};

  // SUB carry follows the 6502 convention: set means no borrow was needed.
  always_comb begin
    flags         = 4'h0;
    eff_mask      = mask;
    flags[FLAG_N] = r[7];
    flags[FLAG_Z] = (r == 8'h00) & low_zero;
    case (op)
      OP_ADD: begin
        flags[FLAG_C] = sum9[8];
        flags[FLAG_V] = (a[7] == b[7]) & (r[7] != a[7]);
      end
      OP_SUB: begin
        flags[FLAG_C] = ({1'b0, a} >= sub_rhs);
        flags[FLAG_V] = (a[7] != b[7]) & (r[7] != a[7]);
      end
      OP_SHL, OP_RTL: begin
        flags[FLAG_C]    = a[7];
        eff_mask[FLAG_V] = 1'b0;
      end
      OP_SHR, OP_RTR: begin
        flags[FLAG_C]    = a[0];
        eff_mask[FLAG_V] = 1'b0;
      end
      default: begin
        eff_mask[FLAG_V] = 1'b0;
        eff_mask[FLAG_C] = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives the 8-bit ALU one request at a time, chaining two passes for
// 16-bit ADD/SUB, and keeps the N/V/Z/C status flags.
module alu_sequencer
  import nes_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_wide,
  input  logic        req_cin,
  input  logic        req_cin_sel,
  input  logic [3:0]  req_flag_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic        resp_err,
  output logic        alu_enable,
  output logic [7:0]  alu_operand1,
  output logic [7:0]  alu_operand2,
  output logic        alu_carrybit,
  output logic [4:0]  alu_op_number,
  input  logic [7:0]  alu_result,
  input  logic        p_load,
  input  logic [3:0]  p_in,
  output logic [3:0]  p_flags
);

  seq_state_t state, state_next;

  logic [4:0]  op_q;
  logic [15:0] a_q, b_q;
  logic        wide_q, cin_q;
  logic [3:0]  mask_q;
  logic [7:0]  lo_res_q;
  logic        lo_carry_q;
  logic [15:0] result_q;
  logic        err_q;
  logic [3:0]  flags_q;

  logic        hi_pass;
  logic [7:0]  pass_a, pass_b;
  logic        pass_cin, pass_carrybit;
  logic [3:0]  unit_flags, unit_mask;
  logic        flag_update, accept, legal;

  assign hi_pass     = (state == S_EXEC_HI) || (state == S_WAIT_HI);
  assign pass_a      = hi_pass ? a_q[15:8] : a_q[7:0];
  assign pass_b      = hi_pass ? b_q[15:8] : b_q[7:0];
  assign pass_cin    = hi_pass ? lo_carry_q : cin_q;
  assign accept      = req_valid & req_ready;
  assign legal       = op_legal(req_op, req_wide);
  assign flag_update = ((state == S_WAIT_LO) && !wide_q) || (state == S_WAIT_HI);

  assign resp_result = result_q;
  assign resp_err    = err_q & (state == S_RESP);
  assign p_flags     = flags_q;

  always_comb begin
    case (op_q)
      OP_ADD, OP_RTL, OP_RTR: pass_carrybit = pass_cin;
      OP_SUB:                 pass_carrybit = ~pass_cin;
      default:                pass_carrybit = 1'b0;
    endcase
  end

  alu_flag_unit u_flags (
    .a        (pass_a),
    .b        (pass_b),
    .cin      (pass_cin),
    .r        (alu_result),
    .low_zero (hi_pass ? (lo_res_q == 8'h00) : 1'b1),
    .op       (op_q),
    .mask     (mask_q),
    .flags    (unit_flags),
    .eff_mask (unit_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    alu_enable    = 1'b0;
    alu_operand1  = 8'h00;
    alu_operand2  = 8'h00;
    alu_carrybit  = 1'b0;
    alu_op_number = 5'd0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = legal ? S_EXEC_LO : S_RESP;
      end
      S_EXEC_LO, S_EXEC_HI: begin
        alu_enable    = 1'b1;
        alu_operand1  = pass_a;
        alu_operand2  = pass_b;
        alu_carrybit  = pass_carrybit;
        alu_op_number = op_q;
        state_next    = (state == S_EXEC_LO) ? S_WAIT_LO : S_WAIT_HI;
      end
      S_WAIT_LO: state_next = wide_q ? S_EXEC_HI : S_RESP;
      S_WAIT_HI: state_next = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A direct flag load always beats the flag write-back from an ALU pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 5'd0;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      wide_q     <= 1'b0;
      cin_q      <= 1'b0;
      mask_q     <= 4'h0;
      lo_res_q   <= 8'h00;
      lo_carry_q <= 1'b0;
      result_q   <= 16'h0000;
      err_q      <= 1'b0;
      flags_q    <= 4'h0;
    end else begin
      if (accept) begin
        op_q     <= req_op;
        a_q      <= req_a;
        b_q      <= req_b;
        wide_q   <= req_wide;
        cin_q    <= req_cin_sel ? flags_q[FLAG_C] : req_cin;
        mask_q   <= req_flag_mask;
        result_q <= 16'h0000;
        err_q    <= ~legal;
      end
      if (state == S_WAIT_LO) begin
        lo_res_q   <= alu_result;
        lo_carry_q <= unit_flags[FLAG_C];
        if (!wide_q) result_q <= {8'h00, alu_result};
      end
      if (state == S_WAIT_HI) result_q <= {alu_result, lo_res_q};
      if (p_load)
        flags_q <= p_in;
      else if (flag_update)
        flags_q <= (flags_q & ~unit_mask) | (unit_flags & unit_mask);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 8-bit ALU beside it,
// a hand-computed vector table and a response scoreboard.
module tb_alu_sequencer;
  import nes_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_wide, req_cin, req_cin_sel;
  logic [3:0]  req_flag_mask;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_result;
  logic        resp_err;
  logic        alu_enable;
  logic [7:0]  alu_operand1, alu_operand2;
  logic        alu_carrybit;
  logic [4:0]  alu_op_number;
  logic [7:0]  alu_result = 8'h00;
  logic        p_load;
  logic [3:0]  p_in;
  logic [3:0]  p_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b;
    logic        wide, cin, cin_sel;
    logic [3:0]  mask;
    logic [15:0] exp_result;
    logic        exp_err;
    logic [3:0]  exp_flags;
    int          exp_lat;
    int          exp_passes;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic        err;
    logic [3:0]  flags;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   en_count;
  logic idle_viol;

  localparam int NV = 20;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_wide(req_wide), .req_cin(req_cin),
    .req_cin_sel(req_cin_sel), .req_flag_mask(req_flag_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .alu_enable(alu_enable), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_carrybit(alu_carrybit), .alu_op_number(alu_op_number), .alu_result(alu_result),
    .p_load(p_load), .p_in(p_in), .p_flags(p_flags)
  );

  // Behavioural ALU: result registered on the edge that sees alu_enable.
  function automatic logic [7:0] alu_model(input logic [4:0] op, input logic [7:0] x,
                                           input logic [7:0] y, input logic cb);
    case (op)
      OP_ADD:  return x + y + {7'h00, cb};
      OP_SUB:  return x - y - {7'h00, cb};
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_INC:  return x + 8'd1;
      OP_DEC:  return x - 8'd1;
      OP_SHR:  return {1'b0, x[7:1]};
      OP_SHL:  return {x[6:0], 1'b0};
      OP_RTR:  return {cb, x[7:1]};
      OP_RTL:  return {x[6:0], cb};
      OP_LD:   return y;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk)
    if (alu_enable) alu_result <= alu_model(alu_op_number, alu_operand1, alu_operand2, alu_carrybit);

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: compare on every response handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (alu_enable) en_count++;
    else if (alu_operand1 != 8'h00 || alu_operand2 != 8'h00 || alu_carrybit || alu_op_number != 5'd0)
      idle_viol = 1'b1;
    if (!reset && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got result 0x%0h, expected no response", resp_result);
      end else begin
        e = sb_q.pop_front();
        check_output($sformatf("t%0d_result", e.tag), resp_result, e.result);
        check_output($sformatf("t%0d_err", e.tag), {15'h0, resp_err}, {15'h0, e.err});
        check_output($sformatf("t%0d_flags", e.tag), {12'h0, p_flags}, {12'h0, e.flags});
      end
    end
  end

  function automatic vec_t make_vec(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic wide, input logic cin, input logic sel,
                                    input logic [3:0] mask, input logic [15:0] res,
                                    input logic err, input logic [3:0] flags);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wide = wide; v.cin = cin; v.cin_sel = sel;
    v.mask = mask; v.exp_result = res; v.exp_err = err; v.exp_flags = flags;
    v.exp_lat    = err ? 1 : (wide ? 5 : 3);
    v.exp_passes = err ? 0 : (wide ? 2 : 1);
    return v;
  endfunction

  // Present a request and return one #1 after its acceptance edge.
  task automatic apply_stimulus(input vec_t v, input int tag, input bit push, output int waits);
    exp_t e;
    req_op = v.op; req_a = v.a; req_b = v.b; req_wide = v.wide;
    req_cin = v.cin; req_cin_sel = v.cin_sel; req_flag_mask = v.mask;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL t%0d_accept: got req_ready=0 for 20 cycles, expected acceptance", tag);
    end
    @(posedge clk);
    en_count  = 0;
    idle_viol = 1'b0;
    if (push) begin
      e.result = v.exp_result; e.err = v.exp_err; e.flags = v.exp_flags; e.tag = tag;
      sb_q.push_back(e);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output($sformatf("t%0d_latency", tag), 16'(lat), 16'(exp_lat));
  endtask

  task automatic finish_resp(input int tag, input int passes);
    @(posedge clk); #1;
    check_output($sformatf("t%0d_enable_pulses", tag), 16'(en_count), 16'(passes));
    check_output($sformatf("t%0d_alu_idle_zero", tag), {15'h0, idle_viol}, 16'h0);
  endtask

  initial begin : main
    int   w;
    logic bad;
    vec_t v;

    vecs[0]  = make_vec(OP_ADD, 16'h0050, 16'h0050, 0, 0, 0, 4'hF, 16'h00A0, 0, 4'hC);
    vecs[1]  = make_vec(OP_SHL, 16'h0081, 16'h0000, 0, 0, 0, 4'hF, 16'h0002, 0, 4'h5);
    vecs[2]  = make_vec(OP_ADD, 16'h12FF, 16'h0001, 1, 0, 0, 4'hF, 16'h1300, 0, 4'h0);
    vecs[3]  = make_vec(OP_SUB, 16'h1000, 16'h0001, 1, 1, 1, 4'hF, 16'h0FFE, 0, 4'h1);
    vecs[4]  = make_vec(OP_SUB, 16'h0080, 16'h0001, 0, 0, 1, 4'hF, 16'h007F, 0, 4'h5);
    vecs[5]  = make_vec(OP_AND, 16'h000F, 16'h00F0, 0, 0, 0, 4'hF, 16'h0000, 0, 4'h7);
    vecs[6]  = make_vec(OP_DEC, 16'h0000, 16'h0000, 0, 0, 0, 4'hF, 16'h00FF, 0, 4'hD);
    vecs[7]  = make_vec(OP_RTR, 16'h0001, 16'h0000, 0, 0, 0, 4'h3, 16'h0000, 0, 4'hF);
    vecs[8]  = make_vec(OP_RTL, 16'h0040, 16'h0000, 0, 1, 0, 4'hF, 16'h0081, 0, 4'hC);
    vecs[9]  = make_vec(OP_XOR, 16'h00AA, 16'h00AA, 0, 0, 0, 4'h0, 16'h0000, 0, 4'hC);
    vecs[10] = make_vec(OP_LD,  16'h0033, 16'h0000, 0, 0, 0, 4'hF, 16'h0000, 0, 4'h6);
    vecs[11] = make_vec(5'd11,  16'h0012, 16'h0034, 0, 0, 0, 4'hF, 16'h0000, 1, 4'h6);
    vecs[12] = make_vec(OP_AND, 16'h1234, 16'h5678, 1, 0, 0, 4'hF, 16'h0000, 1, 4'h6);
    vecs[13] = make_vec(5'd31,  16'h0001, 16'h0001, 0, 0, 0, 4'hF, 16'h0000, 1, 4'h6);
    vecs[14] = make_vec(OP_ADD, 16'h007F, 16'h0001, 0, 0, 0, 4'hF, 16'h0080, 0, 4'hC);
    vecs[15] = make_vec(OP_SUB, 16'h0100, 16'h0100, 1, 1, 0, 4'hF, 16'h0000, 0, 4'h3);
    vecs[16] = make_vec(OP_SHR, 16'h0002, 16'h0000, 0, 0, 0, 4'hF, 16'h0001, 0, 4'h0);
    vecs[17] = make_vec(OP_INC, 16'h00FF, 16'h0000, 0, 0, 0, 4'h2, 16'h0000, 0, 4'h2);
    vecs[18] = make_vec(OP_OR,  16'h0080, 16'h0001, 0, 0, 0, 4'hF, 16'h0081, 0, 4'h8);
    vecs[19] = make_vec(OP_ADD, 16'hAB01, 16'hCD02, 0, 0, 0, 4'hF, 16'h0003, 0, 4'h0);

    reset = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 16'h0; req_b = 16'h0;
    req_wide = 1'b0; req_cin = 1'b0; req_cin_sel = 1'b0; req_flag_mask = 4'h0;
    resp_ready = 1'b1; p_load = 1'b0; p_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req_ready", {15'h0, req_ready}, 16'h1);
    check_output("reset_resp_valid", {15'h0, resp_valid}, 16'h0);
    check_output("reset_resp_err", {15'h0, resp_err}, 16'h0);
    check_output("reset_resp_result", resp_result, 16'h0);
    check_output("reset_alu_outputs", {alu_enable, alu_carrybit, alu_op_number, alu_operand1},
                 16'h0);
    check_output("reset_p_flags", {12'h0, p_flags}, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i], i, 1'b1, w);
      wait_resp(i, vecs[i].exp_lat);
      finish_resp(i, vecs[i].exp_passes);
    end

    // Backpressure: response must hold while the consumer stalls.
    v = make_vec(OP_ADD, 16'h0003, 16'h0004, 0, 0, 0, 4'h0, 16'h0007, 0, vecs[NV-1].exp_flags);
    resp_ready = 1'b0;
    apply_stimulus(v, 100, 1'b1, w);
    wait_resp(100, 3);
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_result !== 16'h0007 || req_ready) bad = 1'b1;
    end
    check_output("bp_hold_stable", {15'h0, bad}, 16'h0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_ready_after_handshake", {15'h0, req_ready}, 16'h1);
    v = make_vec(OP_ADD, 16'h0001, 16'h0001, 0, 0, 0, 4'hF, 16'h0002, 0, 4'h0);
    apply_stimulus(v, 101, 1'b1, w);
    check_output("bp_next_accept_waits", 16'(w), 16'h0);
    wait_resp(101, 3);
    finish_resp(101, 1);

    // Direct flag load while idle, then coincident with a flag write-back.
    p_load = 1'b1; p_in = 4'hA;
    @(posedge clk); #1;
    p_load = 1'b0;
    check_output("pload_idle", {12'h0, p_flags}, 16'hA);
    v = make_vec(OP_ADD, 16'h0050, 16'h0050, 0, 0, 0, 4'hF, 16'h00A0, 0, 4'h5);
    apply_stimulus(v, 102, 1'b1, w);
    @(posedge clk); #1;
    p_load = 1'b1; p_in = 4'h5;
    @(posedge clk); #1;
    p_load = 1'b0;
    check_output("pload_resp_valid", {15'h0, resp_valid}, 16'h1);
    finish_resp(102, 1);

    // Reset landing in EXEC_HI of a wide ADD.
    v = make_vec(OP_ADD, 16'h12FF, 16'h0001, 1, 0, 0, 4'hF, 16'h1300, 0, 4'h0);
    apply_stimulus(v, 103, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("hi_pass_enable", {15'h0, alu_enable}, 16'h1);
    check_output("hi_pass_operands", {alu_operand1, alu_operand2}, 16'h1200);
    check_output("hi_pass_carrybit", {15'h0, alu_carrybit}, 16'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("midreset_idle", {15'h0, req_ready}, 16'h1);
    check_output("midreset_p_flags", {12'h0, p_flags}, 16'h0);
    check_output("midreset_alu_enable", {15'h0, alu_enable}, 16'h0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) bad = 1'b1;
    end
    check_output("midreset_no_resp", {15'h0, bad}, 16'h0);
    check_output("scoreboard_drained", 16'(sb_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
